// File: rtl/konane_pkg.sv
// Shared Konane board constants, FSM encodings and cell index helpers.
// Cells are numbered 6*row+col on the 6x6 board.
package konane_pkg;

  localparam logic BLACK = 1'b0;
  localparam logic WHITE = 1'b1;

  localparam int BOARD_N = 6;
  localparam int CELLS   = BOARD_N * BOARD_N;

  localparam logic [35:0] INIT_BLACK_MOVABLE = 36'h004001004;
  localparam logic [35:0] INIT_WHITE_MOVABLE = 36'h008020008;

  localparam logic signed [4:0] GIVEUP_COORD = -5'sd1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_THINK,
    S_OP,
    S_WAIT_RE
  } state_e;

  typedef enum logic [1:0] {
    K_PIECE,
    K_TARGET,
    K_CONT
  } kind_e;

  localparam logic [2:0] IDX_ROW [CELLS] = '{
    3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
    3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
    3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2,
    3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3,
    3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4,
    3'd5, 3'd5, 3'd5, 3'd5, 3'd5, 3'd5
  };

  localparam logic [2:0] IDX_COL [CELLS] = '{
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5,
    3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5
  };

  function automatic logic [5:0] cell_idx(
    input logic [2:0] i,
    input logic [2:0] j
  );
    return 6'({3'b000, i} * 6'd6 + {3'b000, j});
  endfunction

  // Landing cells two steps away in a straight line, clipped to the board.
  function automatic logic [35:0] ring2(
    input logic [2:0] i,
    input logic [2:0] j
  );
    logic [5:0]  c;
    logic [35:0] m;
    c = cell_idx(i, j);
    m = '0;
    if (i < 3'd4)  m[c + 6'd12] = 1'b1;
    if (i >= 3'd2) m[c - 6'd12] = 1'b1;
    if (j < 3'd4)  m[c + 6'd2]  = 1'b1;
    if (j >= 3'd2) m[c - 6'd2]  = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/konane_cell_pick.sv
// Combinational priority pick of one cell from a 36-bit board mask.
// Returns the lowest (or highest) set cell as (row, col).
module konane_cell_pick
  import konane_pkg::*;
#(
  parameter bit PICK_HIGH = 1'b0
) (
  input  logic [35:0] mask,
  output logic        found,
  output logic [2:0]  i,
  output logic [2:0]  j
);

  logic [5:0] idx;

  // Last write wins, so scan towards the preferred end.
  always_comb begin
    idx = '0;
    if (PICK_HIGH) begin
      for (int k = 0; k < CELLS; k++) begin
        if (mask[k]) idx = 6'(k);
      end
    end else begin
      for (int k = CELLS - 1; k >= 0; k--) begin
        if (mask[k]) idx = 6'(k);
      end
    end
  end

  assign found = |mask;
  assign i     = IDX_ROW[idx];
  assign j     = IDX_COL[idx];

endmodule

// File: rtl/konane_auto_player.sv
// Self-play agent for the konane engine: picks moves from the
// engine's selectable masks over the op/re handshakes.
module konane_auto_player
  import konane_pkg::*;
#(
  parameter int unsigned THINK_CYCLES   = 2,
  parameter bit          PICK_HIGH      = 1'b0,
  parameter bit          CONTINUE_JUMPS = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              start_player,
  input  logic              op_ready,
  output logic              op_valid,
  output logic signed [4:0] op_i,
  output logic signed [4:0] op_j,
  output logic              re_ready,
  input  logic              re_valid,
  input  logic              re_is_finished,
  input  logic              re_next_player_id,
  input  logic              re_player_can_giveup,
  input  logic [35:0]       re_selectable,
  output logic              busy,
  output logic              winner,
  output logic              done_flag,
  output logic [7:0]        games_done,
  output logic [15:0]       moves_done
);

  localparam logic [15:0] THINK_LAST = 16'(THINK_CYCLES);

  state_e             state_q, state_d;
  kind_e              kind_q, kind_d;
  logic [35:0]        cand_q, cand_d;
  logic [2:0]         ci_q, ci_d;
  logic [2:0]         cj_q, cj_d;
  logic [15:0]        cnt_q, cnt_d;
  logic signed [4:0]  op_i_q, op_i_d;
  logic signed [4:0]  op_j_q, op_j_d;
  logic               busy_q, busy_d;
  logic               winner_q, winner_d;
  logic               done_q, done_d;
  logic [7:0]         games_q, games_d;
  logic [15:0]        moves_q, moves_d;

  logic [35:0]        pick_mask;
  logic               pick_found;
  logic [2:0]         pick_i;
  logic [2:0]         pick_j;

  assign pick_mask = (kind_q == K_TARGET)
                   ? (cand_q & ring2(ci_q, cj_q))
                   : cand_q;

  konane_cell_pick #(
    .PICK_HIGH (PICK_HIGH)
  ) u_pick (
    .mask  (pick_mask),
    .found (pick_found),
    .i     (pick_i),
    .j     (pick_j)
  );

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    cand_d   = cand_q;
    ci_d     = ci_q;
    cj_d     = cj_q;
    cnt_d    = cnt_q;
    op_i_d   = op_i_q;
    op_j_d   = op_j_q;
    busy_d   = busy_q;
    winner_d = winner_q;
    done_d   = done_q;
    games_d  = games_q;
    moves_d  = moves_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          cand_d  = start_player ? INIT_WHITE_MOVABLE
                                 : INIT_BLACK_MOVABLE;
          kind_d  = K_PIECE;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          moves_d = '0;
          cnt_d   = '0;
          state_d = S_THINK;
        end
      end
      S_THINK: begin
        if (cnt_q != THINK_LAST) begin
          cnt_d = cnt_q + 16'd1;
        end else if (kind_q == K_CONT &&
                     (!CONTINUE_JUMPS || !pick_found)) begin
          op_i_d  = GIVEUP_COORD;
          op_j_d  = GIVEUP_COORD;
          state_d = S_OP;
        end else if (!pick_found) begin
          // Nothing legal offered: the engine broke protocol.
          busy_d  = 1'b0;
          done_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          op_i_d  = {2'b00, pick_i};
          op_j_d  = {2'b00, pick_j};
          if (kind_q == K_PIECE) begin
            ci_d = pick_i;
            cj_d = pick_j;
          end
          state_d = S_OP;
        end
      end
      S_OP: begin
        if (op_ready) begin
          if (moves_q != 16'hFFFF) moves_d = moves_q + 16'd1;
          state_d = S_WAIT_RE;
        end
      end
      S_WAIT_RE: begin
        if (re_valid) begin
          if (re_is_finished) begin
            winner_d = re_player_can_giveup ? re_next_player_id
                                            : ~re_next_player_id;
            done_d   = 1'b1;
            games_d  = games_q + 8'd1;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
          end else begin
            cand_d = re_selectable;
            cnt_d  = '0;
            if (kind_q == K_PIECE)         kind_d = K_TARGET;
            else if (re_player_can_giveup) kind_d = K_CONT;
            else                           kind_d = K_PIECE;
            state_d = S_THINK;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      kind_q   <= K_PIECE;
      cand_q   <= '0;
      ci_q     <= '0;
      cj_q     <= '0;
      cnt_q    <= '0;
      op_i_q   <= '0;
      op_j_q   <= '0;
      busy_q   <= 1'b0;
      winner_q <= 1'b0;
      done_q   <= 1'b0;
      games_q  <= '0;
      moves_q  <= '0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cand_q   <= cand_d;
      ci_q     <= ci_d;
      cj_q     <= cj_d;
      cnt_q    <= cnt_d;
      op_i_q   <= op_i_d;
      op_j_q   <= op_j_d;
      busy_q   <= busy_d;
      winner_q <= winner_d;
      done_q   <= done_d;
      games_q  <= games_d;
      moves_q  <= moves_d;
    end
  end

  assign op_valid   = (state_q == S_OP);
  assign re_ready   = (state_q == S_WAIT_RE);
  assign op_i       = op_i_q;
  assign op_j       = op_j_q;
  assign busy       = busy_q;
  assign winner     = winner_q;
  assign done_flag  = done_q;
  assign games_done = games_q;
  assign moves_done = moves_q;

endmodule

// File: tb/tb_konane_auto_player.sv
// Scripted-engine bench for konane_auto_player: two agents with
// different pick/continue settings share one stimulus path.
module tb_konane_auto_player;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        start_player = 1'b0;
  logic        op_ready = 1'b0;
  logic        re_valid = 1'b0;
  logic        re_fin = 1'b0;
  logic        re_nxt = 1'b0;
  logic        re_cg = 1'b0;
  logic [35:0] re_sel = '0;
  logic        sel = 1'b0;

  logic        a_op_valid, a_re_ready, a_busy, a_winner, a_done;
  logic [4:0]  a_op_i, a_op_j;
  logic [7:0]  a_games;
  logic [15:0] a_moves;
  logic        b_op_valid, b_re_ready, b_busy, b_winner, b_done;
  logic [4:0]  b_op_i, b_op_j;
  logic [7:0]  b_games;
  logic [15:0] b_moves;

  logic        m_op_valid, m_re_ready, m_busy, m_winner, m_done;
  logic [4:0]  m_op_i, m_op_j;
  logic [7:0]  m_games;
  logic [15:0] m_moves;

  logic [9:0]  exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  konane_auto_player #(
    .THINK_CYCLES   (0),
    .PICK_HIGH      (1'b0),
    .CONTINUE_JUMPS (1'b1)
  ) dut_a (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start & ~sel),
    .start_player         (start_player),
    .op_ready             (op_ready & ~sel),
    .op_valid             (a_op_valid),
    .op_i                 (a_op_i),
    .op_j                 (a_op_j),
    .re_ready             (a_re_ready),
    .re_valid             (re_valid & ~sel),
    .re_is_finished       (re_fin),
    .re_next_player_id    (re_nxt),
    .re_player_can_giveup (re_cg),
    .re_selectable        (re_sel),
    .busy                 (a_busy),
    .winner               (a_winner),
    .done_flag            (a_done),
    .games_done           (a_games),
    .moves_done           (a_moves)
  );

  konane_auto_player #(
    .THINK_CYCLES   (2),
    .PICK_HIGH      (1'b1),
    .CONTINUE_JUMPS (1'b0)
  ) dut_b (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start & sel),
    .start_player         (start_player),
    .op_ready             (op_ready & sel),
    .op_valid             (b_op_valid),
    .op_i                 (b_op_i),
    .op_j                 (b_op_j),
    .re_ready             (b_re_ready),
    .re_valid             (re_valid & sel),
    .re_is_finished       (re_fin),
    .re_next_player_id    (re_nxt),
    .re_player_can_giveup (re_cg),
    .re_selectable        (re_sel),
    .busy                 (b_busy),
    .winner               (b_winner),
    .done_flag            (b_done),
    .games_done           (b_games),
    .moves_done           (b_moves)
  );

  assign m_op_valid = sel ? b_op_valid : a_op_valid;
  assign m_re_ready = sel ? b_re_ready : a_re_ready;
  assign m_busy     = sel ? b_busy     : a_busy;
  assign m_winner   = sel ? b_winner   : a_winner;
  assign m_done     = sel ? b_done     : a_done;
  assign m_op_i     = sel ? b_op_i     : a_op_i;
  assign m_op_j     = sel ? b_op_j     : a_op_j;
  assign m_games    = sel ? b_games    : a_games;
  assign m_moves    = sel ? b_moves    : a_moves;

  function automatic logic [9:0] rc(input int i, input int j);
    return {5'(i), 5'(j)};
  endfunction

  function automatic logic [35:0] b(input int k);
    logic [35:0] one;
    one = 36'd1;
    return one << k;
  endfunction

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic kick(input logic pl, input logic [9:0] first);
    exp_q.push_back(first);
    start_player = pl;
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic serve_op(
    input string       tag,
    input int          hold,
    input logic [15:0] mv
  );
    int         n;
    logic [9:0] e;
    n = 0;
    while (m_op_valid !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    check({tag, ".valid"}, 32'(m_op_valid), 32'd1);
    if (m_op_valid !== 1'b1) return;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h2AA;
    check({tag, ".i"}, 32'(m_op_i), 32'(e[9:5]));
    check({tag, ".j"}, 32'(m_op_j), 32'(e[4:0]));
    op_ready = 1'b0;
    repeat (hold) begin
      tick(1);
      check({tag, ".hold"},
            32'({m_op_valid, m_op_i, m_op_j}),
            32'({1'b1, e}));
    end
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    check({tag, ".drop"}, 32'(m_op_valid), 32'd0);
    check({tag, ".moves"}, 32'(m_moves), 32'(mv));
  endtask

  task automatic respond(
    input logic        fin,
    input logic        nxt,
    input logic        cg,
    input logic [35:0] s,
    input bit          push,
    input logic [9:0]  nexp
  );
    int n;
    n = 0;
    while (m_re_ready !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    check("re.ready", 32'(m_re_ready), 32'd1);
    if (push) exp_q.push_back(nexp);
    re_fin   = fin;
    re_nxt   = nxt;
    re_cg    = cg;
    re_sel   = s;
    re_valid = 1'b1;
    tick(1);
    re_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    sel = 1'b0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst.op_valid", 32'(m_op_valid), 32'd0);
    check("rst.re_ready", 32'(m_re_ready), 32'd0);
    check("rst.busy",     32'(m_busy),     32'd0);
    check("rst.done",     32'(m_done),     32'd0);
    check("rst.games",    32'(m_games),    32'd0);
    check("rst.moves",    32'(m_moves),    32'd0);
    check("rst.op_ij",    32'({m_op_i, m_op_j}), 32'd0);

    // Black opening, target via ring filter, continuation, give-up.
    kick(1'b0, rc(0, 2));
    serve_op("a.p0", 0, 16'd1);
    check("a.busy", 32'(m_busy), 32'd1);
    respond(1'b0, 1'b0, 1'b0, b(14) | b(2) | b(12) | b(26), 1, rc(2, 2));
    serve_op("a.t0", 5, 16'd2);
    respond(1'b0, 1'b0, 1'b1, b(26), 1, rc(4, 2));
    serve_op("a.c0", 0, 16'd3);
    respond(1'b0, 1'b0, 1'b1, 36'd0, 1, rc(31, 31));
    serve_op("a.c1", 0, 16'd4);
    respond(1'b0, 1'b1, 1'b0, b(3) | b(17) | b(27), 1, rc(0, 3));
    serve_op("a.p1", 0, 16'd5);
    respond(1'b1, 1'b1, 1'b0, 36'd0, 0, 10'd0);
    tick(1);
    check("a.fin.done",   32'(m_done),   32'd1);
    check("a.fin.winner", 32'(m_winner), 32'd0);
    check("a.fin.games",  32'(m_games),  32'd1);
    check("a.fin.busy",   32'(m_busy),   32'd0);
    n = 0;
    repeat (10) begin
      tick(1);
      if (m_op_valid) n++;
    end
    check("a.fin.quiet", 32'(n), 32'd0);

    // White game, then reset while waiting for the engine.
    kick(1'b1, rc(0, 3));
    serve_op("a.w0", 0, 16'd1);
    check("a.w0.done", 32'(m_done), 32'd0);
    respond(1'b0, 1'b0, 1'b0, b(1) | b(15), 1, rc(0, 1));
    serve_op("a.w1", 0, 16'd2);
    check("a.w1.re_ready", 32'(m_re_ready), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("a.rst.op_valid", 32'(m_op_valid), 32'd0);
    check("a.rst.re_ready", 32'(m_re_ready), 32'd0);
    check("a.rst.busy",     32'(m_busy),     32'd0);
    check("a.rst.games",    32'(m_games),    32'd0);
    check("a.rst.moves",    32'(m_moves),    32'd0);

    // Target mask with no landing cell near the piece.
    kick(1'b0, rc(0, 2));
    serve_op("a.e0", 0, 16'd1);
    respond(1'b0, 1'b0, 1'b0, b(35), 0, 10'd0);
    tick(4);
    check("a.err.busy",     32'(m_busy),     32'd0);
    check("a.err.done",     32'(m_done),     32'd0);
    check("a.err.op_valid", 32'(m_op_valid), 32'd0);
    check("a.err.re_ready", 32'(m_re_ready), 32'd0);

    // Agent B: pick-high, never continue, slower thinking.
    sel = 1'b1;
    tick(1);
    kick(1'b0, rc(4, 2));
    serve_op("b.p0", 0, 16'd1);
    respond(1'b0, 1'b0, 1'b0, b(14) | b(24) | b(28) | b(35), 1, rc(4, 4));
    serve_op("b.t0", 0, 16'd2);
    respond(1'b0, 1'b0, 1'b1, b(16), 1, rc(31, 31));
    serve_op("b.c0", 0, 16'd3);
    respond(1'b1, 1'b1, 1'b1, 36'd0, 0, 10'd0);
    tick(2);
    check("b.g1.winner", 32'(m_winner), 32'd1);
    check("b.g1.games",  32'(m_games),  32'd1);
    check("b.g1.done",   32'(m_done),   32'd1);
    kick(1'b1, rc(4, 3));
    serve_op("b.w0", 2, 16'd1);
    respond(1'b1, 1'b0, 1'b0, 36'd0, 0, 10'd0);
    tick(2);
    check("b.g2.winner", 32'(m_winner), 32'd1);
    check("b.g2.games",  32'(m_games),  32'd2);
    check("b.g2.busy",   32'(m_busy),   32'd0);
    check("b.leftover",  32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/konane_auto_player.md
Name: konane_auto_player

Overview:
- Initiator-side agent that plays Konane against the konane engine.
- Drives the engine's op channel (op_valid/op_ready/op_i/op_j) and consumes its re channel (re_valid/re_ready/re_*).
- Picks moves from the engine's re_selectable masks. Plays both colours from a host start pulse until the engine reports a finished game.
- Sits between the host/testbench shell and konane; used for self-play regression and bring-up.

Parameters:
- THINK_CYCLES, 2, idle cycles between re fire and the next op_valid assertion (0 = next cycle).
- PICK_HIGH, 0, 0 = choose the lowest set index of a candidate mask; 1 = choose the highest.
- CONTINUE_JUMPS, 1, 1 = take a multi-jump continuation when offered; 0 = always give up with (-1,-1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a game when idle.
- start_player  in  1  colour the engine expects first (0 = BLACK, 1 = WHITE); sampled on start.
- op_ready  in  1  engine accepts op.
- op_valid  out  1  op offered.
- op_i  out  5 signed  row (0..5), or -1 for give-up.
- op_j  out  5 signed  column (0..5), or -1 for give-up.
- re_ready  out  1  agent accepts response.
- re_valid  in  1  response offered.
- re_is_finished  in  1  game over.
- re_next_player_id  in  1  player to move next.
- re_player_can_giveup  in  1  continuation is optional.
- re_selectable  in  36  cell mask, bit 6*i+j.
- busy  out  1  game in progress.
- winner  out  1  last game winner; valid while done_flag is 1.
- done_flag  out  1  set when a game finishes; cleared on start.
- games_done  out  8  finished-game counter; wraps at 255 to 0.
- moves_done  out  16  op fires in the current game; saturates at 65535.

Behaviour:
- Reset values: all outputs 0 (busy=0, op_valid=0, re_ready=0, op_i=op_j=0, done_flag=0, counters 0). State goes to IDLE; cand mask is 0.
- Reset mid-game: the agent abandons the game immediately. The engine must be reset alongside it.
- States: IDLE, THINK, OP, WAIT_RE.
- IDLE:
  - start loads cand = INIT_MASK[start_player].
  - Black initial mask: bits {2,12,26}. White initial mask: bits {3,17,27}.
  - Sets kind = PIECE, busy=1, done_flag=0, moves_done=0, then goes to THINK.
  - start while busy is ignored.
- THINK:
  - Counts THINK_CYCLES cycles, then registers the choice into op_i/op_j and goes to OP.
  - Choice for PIECE: pick(cand).
  - Choice for TARGET: pick(cand & ring2(ci,cj)). ring2 is the in-bounds cells at distance exactly 2, straight line, from the chosen piece.
  - Choice for CONT with CONTINUE_JUMPS=1: pick(cand).
  - Choice for CONT with CONTINUE_JUMPS=0: (-1,-1).
  - On PIECE, ci/cj latch the chosen cell.
- OP:
  - op_valid=1; op_i/op_j stay stable until op_ready&op_valid.
  - On fire: op_valid drops the next cycle, moves_done increments, state goes to WAIT_RE.
  - Exception: a PIECE fire leads to WAIT_RE as well; the engine answers every op except TARGET/CONT with a response, and TARGET/CONT are also followed by a response. WAIT_RE is therefore always entered.
- WAIT_RE:
  - re_ready=1; on re_valid the agent samples all re_* in that cycle.
  - If finished:
    - winner = re_player_can_giveup ? re_next_player_id : ~re_next_player_id.
    - done_flag=1, games_done increments, busy=0, then IDLE.
  - Else, choose the next kind:
    - Previous kind PIECE (choose response): next kind = TARGET, cand=re_selectable.
    - re_player_can_giveup=1: next kind = CONT, cand=re_selectable.
    - Otherwise (turn passed): next kind = PIECE, cand=re_selectable.
  - Then go to THINK.
- Empty candidate in THINK: with kind CONT, give up. With any other kind this is a protocol error; the agent parks in IDLE with busy=0 and done_flag=0.
- Index→(i,j) conversion: i = idx/6, j = idx%6 via a 36-entry constant table. No divider.
- Outputs are driven directly from registers; no combinational path from re_* to op_*.

Decomposition:
- Package konane_pkg:
  - BLACK/WHITE constants.
  - BOARD_N=6.
  - INIT_BLACK_MOVABLE and INIT_WHITE_MOVABLE masks.
  - GIVEUP_COORD=-1.
  - idx↔(i,j) table.
- Sub-module konane_cell_pick:
  - 36-bit mask plus PICK_HIGH in; found, i, j out.
  - Purely combinational priority encoder; registered by the parent.
  - Also used by the engine's future bench.

Test Plan:
- Reset, start with start_player=0, THINK_CYCLES=0 -> first op (0,2). Engine re_selectable = bit14|{2,12,26} -> next op (2,2), not (0,0).
- Engine response re_player_can_giveup=1, re_selectable=bit26, CONTINUE_JUMPS=1 -> op (4,2). Same with CONTINUE_JUMPS=0 -> op (-1,-1).
- Response with re_is_finished=1, re_player_can_giveup=0, re_next_player_id=1 -> winner=0, done_flag=1, games_done=1, busy=0; no further op_valid.
- op_ready held low for 5 cycles in OP -> op_valid stays 1 with constant op_i/op_j; exactly one moves_done increment on fire.
- rst asserted while in WAIT_RE -> next cycle op_valid=0, re_ready=0, busy=0, games_done=0.
- Full self-play against konane with THINK_CYCLES=2, PICK_HIGH=1 -> game finishes, games_done=1. Repeat with a second start -> games_done=2.
